// File: rtl/mod_counter_ctrl.sv
// Prescaled enable generator and final-value loader for a downstream modulus counter.
// Define MOD_COUNTER_CTRL_ONESHOT_EN to end a run at the first wrap when one_shot was latched.
module mod_counter_ctrl #(
  parameter int              BITS        = 4,
  parameter int              PRE_BITS    = 8,
  parameter logic [BITS-1:0] RESET_FINAL = {BITS{1'b1}}
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stop,
  input  logic                one_shot,
  input  logic [PRE_BITS-1:0] prescale,
  input  logic                ld_valid,
  input  logic [BITS-1:0]     ld_value,
  output logic                ld_ready,
  input  logic [BITS-1:0]     cnt_q,
  output logic                cnt_enable,
  output logic [BITS-1:0]     final_value,
  output logic                wrap,
  output logic                busy
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [PRE_BITS-1:0] PRE_ONE = 1;

  state_t              state_q, state_d;
  logic [PRE_BITS-1:0] pre_cnt_q, pre_cnt_d;
  logic [PRE_BITS-1:0] prescale_q, prescale_d;
  logic                one_shot_q, one_shot_d;
  logic                en_q, en_d;
  logic [BITS-1:0]     final_q, final_d;
  logic [BITS-1:0]     pend_q, pend_d;
  logic                pend_valid_q, pend_valid_d;
  logic                ld_acc;
  logic                os_exit;

  assign ld_ready    = ~pend_valid_q;
  assign ld_acc      = ld_valid & ~pend_valid_q;
  assign cnt_enable  = en_q;
  assign final_value = final_q;
  assign wrap        = en_q & (cnt_q == final_q);
  assign busy        = (state_q != IDLE);

`ifdef MOD_COUNTER_CTRL_ONESHOT_EN
  assign os_exit = one_shot_q & wrap;
`else
  // one_shot is still latched but cannot end a run in this build
  assign os_exit = 1'b0 & one_shot_q;
`endif

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    prescale_d   = prescale_q;
    one_shot_d   = one_shot_q;
    en_d         = 1'b0;
    final_d      = final_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    case (state_q)
      IDLE: begin
        if (ld_acc) final_d = ld_value;
        if (start && !stop) begin
          state_d    = RUN;
          pre_cnt_d  = '0;
          prescale_d = prescale;
          one_shot_d = one_shot;
        end
      end
      RUN: begin
        if (stop || os_exit) begin
          // leaving RUN: the newest offered value wins, otherwise drain the pending slot
          state_d      = IDLE;
          pre_cnt_d    = '0;
          pend_valid_d = 1'b0;
          if (ld_acc)            final_d = ld_value;
          else if (pend_valid_q) final_d = pend_q;
        end else begin
          if (pre_cnt_q == prescale_q) begin
            pre_cnt_d = '0;
            en_d      = 1'b1;
          end else begin
            pre_cnt_d = pre_cnt_q + PRE_ONE;
          end
          if (wrap && pend_valid_q) begin
            final_d      = pend_q;
            pend_valid_d = 1'b0;
          end
          if (ld_acc) begin
            pend_d       = ld_value;
            pend_valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pre_cnt_q    <= '0;
      prescale_q   <= '0;
      one_shot_q   <= 1'b0;
      en_q         <= 1'b0;
      final_q      <= RESET_FINAL;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      prescale_q   <= prescale_d;
      one_shot_q   <= one_shot_d;
      en_q         <= en_d;
      final_q      <= final_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end

endmodule
